// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: an integer period counter stretched by one
// cycle whenever a fractional accumulator carries, plus an oversample phase counter.
module baud_gen_frac #(
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              div_int,
    input  logic [FRAC_BITS-1:0]          div_frac,
    input  logic                          update,
    input  logic                          realign,
    output logic                          ce_os,
    output logic                          ce_bit,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

    logic [WIDTH-1:0]     div_int_q;
    logic [FRAC_BITS-1:0] div_frac_q;
    logic [WIDTH-1:0]     cnt;
    logic [FRAC_BITS-1:0] acc;
    logic                 ext;
    logic [OS_W-1:0]      os_cnt;

    logic [WIDTH:0]       limit;
    logic                 wrap;
    logic [FRAC_BITS:0]   acc_sum;

    // Limit is kept one bit wider so div_int_q at full scale plus ext never truncates.
    assign limit    = {1'b0, div_int_q} + {{WIDTH{1'b0}}, ext};
    assign wrap     = ({1'b0, cnt} == limit);
    assign acc_sum  = {1'b0, acc} + {1'b0, div_frac_q};
    assign os_phase = os_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_int_q  <= '0;
            div_frac_q <= '0;
            cnt        <= '0;
            acc        <= '0;
            ext        <= 1'b0;
            os_cnt     <= '0;
            ce_os      <= 1'b0;
            ce_bit     <= 1'b0;
        end else if (update) begin
            div_int_q  <= div_int;
            div_frac_q <= div_frac;
            cnt        <= '0;
            acc        <= '0;
            ext        <= 1'b0;
            os_cnt     <= '0;
            ce_os      <= 1'b0;
            ce_bit     <= 1'b0;
        end else if (realign) begin
            // Starting half-way through the bit puts the next ce_bit at mid-bit.
            cnt        <= '0;
            acc        <= '0;
            ext        <= 1'b0;
            os_cnt     <= OS_HALF;
            ce_os      <= 1'b0;
            ce_bit     <= 1'b0;
        end else if (enable) begin
            if (wrap) begin
                cnt    <= '0;
                acc    <= acc_sum[FRAC_BITS-1:0];
                ext    <= acc_sum[FRAC_BITS];
                os_cnt <= os_cnt + OS_W'(1);
                ce_os  <= 1'b1;
                ce_bit <= (os_cnt == OS_LAST);
            end else begin
                cnt    <= cnt + WIDTH'(1);
                ce_os  <= 1'b0;
                ce_bit <= 1'b0;
            end
        end else begin
            ce_os  <= 1'b0;
            ce_bit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac with default parameters (WIDTH=16, FRAC_BITS=4,
// OVERSAMPLE=16); inputs change and outputs are sampled on the falling edge.
module tb_baud_gen_frac;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        update;
    logic        realign;
    logic        ce_os;
    logic        ce_bit;
    logic [3:0]  os_phase;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int total;
    int ticks;

    baud_gen_frac #(.WIDTH(16), .FRAC_BITS(4), .OVERSAMPLE(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .div_int  (div_int),
        .div_frac (div_frac),
        .update   (update),
        .realign  (realign),
        .ce_os    (ce_os),
        .ce_bit   (ce_bit),
        .os_phase (os_phase)
    );

    always #5 clock = ~clock;

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Falling edges until ce_os is seen; -1 on timeout.
    task automatic wait_ce_os(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (ce_os !== 1'b1 && cycles < 2000);
        if (ce_os !== 1'b1) cycles = -1;
    endtask

    task automatic wait_ce_bit(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (ce_bit !== 1'b1 && cycles < 2000);
        if (ce_bit !== 1'b1) cycles = -1;
    endtask

    task automatic do_update(input logic [15:0] di, input logic [3:0] df);
        div_int  = di;
        div_frac = df;
        update   = 1'b1;
        step(1);
        update   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; div_int = '0; div_frac = '0;
        update = 1'b0; realign = 1'b0;

        // Reset state
        step(2);
        check("reset_ce_os", ce_os, 0);
        check("reset_ce_bit", ce_bit, 0);
        check("reset_os_phase", os_phase, 0);
        reset = 1'b0;

        // Integer divisor 9: 10-cycle ce_os, 160-cycle ce_bit
        enable = 1'b1;
        do_update(16'd9, 4'd0);
        check("upd_no_tick", ce_os, 0);
        check("upd_os_phase", os_phase, 0);
        wait_ce_os(n);
        check("int_first_period", n, 10);
        check("int_phase_after_tick", os_phase, 1);
        step(1);
        check("int_tick_one_cycle", ce_os, 0);
        wait_ce_os(n);
        check("int_second_period", n, 9);
        wait_ce_bit(n);
        check("int_bit_from_tick2", n, 140);
        check("int_bit_with_os", ce_os, 1);
        check("int_bit_phase", os_phase, 0);
        wait_ce_bit(n);
        check("int_bit_period", n, 160);

        // Fractional divisor 9 + 8/16: periods 10,10,11,10 then alternating
        do_update(16'd9, 4'd8);
        wait_ce_os(n);
        check("frac_p1", n, 10);
        wait_ce_os(n);
        check("frac_p2", n, 10);
        wait_ce_os(n);
        check("frac_p3", n, 11);
        wait_ce_os(n);
        check("frac_p4", n, 10);
        total = 0;
        for (int i = 0; i < 32; i++) begin
            wait_ce_os(n);
            total += n;
        end
        check("frac_32_ticks_span", total, 336);

        // Realign on the wrap cycle: tick suppressed, phase 8, ce_bit on 8th ce_os
        do_update(16'd9, 4'd0);
        wait_ce_os(n);
        check("ra_sync_tick", n, 10);
        step(9);
        realign = 1'b1;
        step(1);
        realign = 1'b0;
        check("ra_no_tick", ce_os, 0);
        check("ra_phase", os_phase, 8);
        ticks = 0;
        total = 0;
        while (ce_bit !== 1'b1 && total < 2000) begin
            step(1);
            total++;
            if (ce_os === 1'b1) ticks++;
        end
        check("ra_bit_cycles", total, 80);
        check("ra_bit_on_8th_tick", ticks, 8);

        // Enable dropped 5 cycles mid-period delays the tick by 5
        do_update(16'd9, 4'd0);
        wait_ce_os(n);
        check("en_sync_tick", n, 10);
        step(4);
        enable = 1'b0;
        step(5);
        check("en_frozen_no_tick", ce_os, 0);
        check("en_frozen_phase", os_phase, 1);
        enable = 1'b1;
        wait_ce_os(n);
        check("en_resume_remaining", n, 6);
        check("en_phase_after", os_phase, 2);

        // Update and realign together at the wrap cycle
        step(9);
        div_int = 16'd4; div_frac = 4'd0;
        update = 1'b1; realign = 1'b1;
        step(1);
        update = 1'b0; realign = 1'b0;
        check("ur_no_tick", ce_os, 0);
        check("ur_phase", os_phase, 0);
        wait_ce_os(n);
        check("ur_new_period", n, 5);

        // Realign with enable low still takes effect
        enable = 1'b0;
        realign = 1'b1;
        step(1);
        realign = 1'b0;
        check("ra_disabled_phase", os_phase, 8);
        check("ra_disabled_no_tick", ce_os, 0);
        enable = 1'b1;

        // Divisor 0/0: ce_os every cycle, ce_bit every 16
        do_update(16'd0, 4'd0);
        check("zero_upd_no_tick", ce_os, 0);
        wait_ce_os(n);
        check("zero_first", n, 1);
        wait_ce_os(n);
        check("zero_second", n, 1);
        wait_ce_bit(n);
        check("zero_bit_first", n, 14);
        wait_ce_bit(n);
        check("zero_bit_period", n, 16);

        // Asynchronous reset while a tick is high, strobes ignored during reset
        do_update(16'd9, 4'd0);
        wait_ce_os(n);
        check("rst_sync_tick", n, 10);
        #2 reset = 1'b1;
        #1;
        check("rst_async_ce_os", ce_os, 0);
        check("rst_async_phase", os_phase, 0);
        step(1);
        div_int = 16'd7; update = 1'b1; realign = 1'b1;
        step(1);
        check("rst_strobes_ignored", os_phase, 0);
        update = 1'b0; realign = 1'b0;
        reset = 1'b0;
        step(1);
        check("rst_release_tick1", ce_os, 1);
        step(1);
        check("rst_release_tick2", ce_os, 1);
        check("rst_release_phase", os_phase, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter WIDTH, default 16: width of the integer divisor and the period counter.
REQ-002 Parameter FRAC_BITS, default 4: width of the fractional divisor and the accumulator, 1..8.
REQ-003 Parameter OVERSAMPLE, default 16: oversample ticks per bit; power of two, >= 2.
REQ-004 clock  in  1  system clock, rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  count enable; 0 freezes all state.
REQ-007 div_int  in  WIDTH  integer divisor, latched on update.
REQ-008 div_frac  in  FRAC_BITS  fractional divisor in 1/2^FRAC_BITS cycles, latched on update.
REQ-009 update  in  1  one-cycle strobe: load divisors and restart all phases.
REQ-010 realign  in  1  one-cycle strobe: restart phase so ce_bit lands mid-bit (RX start-bit sync).
REQ-011 ce_os  out  1  one-cycle oversample tick.
REQ-012 ce_bit  out  1  one-cycle bit tick, coincident with every OVERSAMPLE-th ce_os.
REQ-013 os_phase  out  log2(OVERSAMPLE)  current oversample index, os_cnt.

Function
REQ-014 Internal state: div_int_q, div_frac_q, cnt (WIDTH), acc (FRAC_BITS), ext (1), os_cnt (log2 OVERSAMPLE).
REQ-015 Period limit SHALL be the (WIDTH+1)-bit value {0,div_int_q} + ext; the comparison of cnt to limit SHALL be performed at WIDTH+1 bits (no truncation).
REQ-016 Each ce_os period SHALL be div_int_q+1+ext clock cycles; the long-run mean SHALL be div_int_q+1+div_frac_q/2^FRAC_BITS.
REQ-017 Wrap event (enable=1, no update/realign, cnt==limit): cnt<=0; {carry,acc}<=acc+div_frac_q; ext<=carry; os_cnt<=os_cnt+1 mod OVERSAMPLE.
REQ-018 Non-wrap (enable=1, no update/realign): cnt<=cnt+1; acc, ext, os_cnt held.
REQ-019 ce_os SHALL be registered: high exactly one cycle, the cycle after a wrap event.
REQ-020 ce_bit SHALL be registered: high the cycle after a wrap event in which os_cnt==OVERSAMPLE-1.
REQ-021 enable=0: cnt, acc, ext, os_cnt held; ce_os=ce_bit=0 the next cycle.
REQ-022 update=1: div_int_q<=div_int, div_frac_q<=div_frac, cnt<=0, acc<=0, ext<=0, os_cnt<=0; ce_os=ce_bit=0 the next cycle; independent of enable.
REQ-023 realign=1 (update=0): cnt<=0, acc<=0, ext<=0, os_cnt<=OVERSAMPLE/2; divisors kept; ce_os=ce_bit=0 the next cycle; independent of enable.
REQ-024 Priority: reset > update > realign > enable/wrap; a wrap coinciding with update or realign SHALL NOT produce a tick.
REQ-025 div_int_q=0 with div_frac_q=0: ce_os SHALL be high every cycle; ce_bit SHALL be high every OVERSAMPLE cycles.
REQ-026 The first ce_bit after realign SHALL occur on the OVERSAMPLE/2-th ce_os.
REQ-027 os_phase SHALL equal os_cnt combinationally from the register, with no added latency.

Reset
REQ-028 Reset asserted SHALL immediately clear div_int_q, div_frac_q, cnt, acc, ext, os_cnt, ce_os and ce_bit to 0, regardless of clock.
REQ-029 Reset deasserted mid-operation SHALL resume counting from the all-zero state on the next rising edge; enable and strobes are ignored while reset=1.

Verification
REQ-030 OVERSAMPLE=16, update with div_int=9, div_frac=0, enable=1 -> ce_os every 10 cycles; ce_bit every 160 cycles; first ce_os 10 cycles after the cycle following update.
REQ-031 FRAC_BITS=4, div_int=9, div_frac=8 -> periods alternate 10,11; 32 ce_os ticks span exactly 336 cycles.
REQ-032 Steady ticking, realign pulsed -> no tick next cycle; os_phase=8; first ce_bit on the 8th subsequent ce_os.
REQ-033 enable dropped for 5 cycles mid-period -> tick delayed by exactly 5 cycles; os_phase unchanged.
REQ-034 update and realign together at the cycle cnt==limit -> no ce_os; os_phase=0; new divisor used.
REQ-035 Reset asserted between clock edges mid-count -> all outputs 0 immediately; after release with div_int_q=0, ce_os high every cycle.
